ddr_data_phase_timer: RTL and testbench

- Downstream neighbour of the bank timing FSM. It consumes the same one-hot command vector and bank address and produces the data-bus phase windows.
- For each RD/RDA it asserts a read-data enable T_CL cycles later for BL/2 clocks. For each WR/WRA it asserts a write-data enable T_CWL cycles later for BL/2 clocks.
- Tags each window with its bankgroup/bank and a beat index, and flags protocol violations (overlapping bursts, read/write bus collision, illegal multi-command).

---
 rtl/ddr_data_phase_timer_if.sv | 47 ++++
 rtl/ddr_data_phase_timer.sv | 216 +++++++++++++++++++++
 tb/tb_ddr_data_phase_timer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr_data_phase_timer_if.sv
// ddr_data_phase_timer_if
//   Bundles the command input and the data-phase window outputs of
//   ddr_data_phase_timer.
//   master : command source (bank timing FSM side); drives bg/ba/commands and
//            observes the windows and error flags.
//   slave  : the data phase timer; samples commands, drives windows and flags.
//   Signals:
//     bg, ba        bankgroup / bank of the command sampled this edge
//     commands      19-bit one-hot command vector (bit5 RD, bit4 RDA,
//                   bit1 WR, bit0 WRA)
//     rd_en/rd_bg/rd_ba/rd_beat   read data phase window and its tags
//     wr_en/wr_bg/wr_ba/wr_beat   write data phase window and its tags
//     overlap_err, bus_conflict, cmd_err   sticky protocol error flags
interface ddr_data_phase_timer_if #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int BL      = 8
);
  logic [BGWIDTH-1:0]        bg;
  logic [BAWIDTH-1:0]        ba;
  logic [18:0]               commands;
  logic                      rd_en;
  logic [BGWIDTH-1:0]        rd_bg;
  logic [BAWIDTH-1:0]        rd_ba;
  logic [$clog2(BL/2)-1:0]   rd_beat;
  logic                      wr_en;
  logic [BGWIDTH-1:0]        wr_bg;
  logic [BAWIDTH-1:0]        wr_ba;
  logic [$clog2(BL/2):0]     wr_beat;
  logic                      overlap_err;
  logic                      bus_conflict;
  logic                      cmd_err;

  modport master (
    output bg, ba, commands,
    input  rd_en, rd_bg, rd_ba, rd_beat,
    input  wr_en, wr_bg, wr_ba, wr_beat,
    input  overlap_err, bus_conflict, cmd_err
  );

  modport slave (
    input  bg, ba, commands,
    output rd_en, rd_bg, rd_ba, rd_beat,
    output wr_en, wr_bg, wr_ba, wr_beat,
    output overlap_err, bus_conflict, cmd_err
  );
endinterface

// File: rtl/ddr_data_phase_timer.sv
// ddr_data_phase_timer
//   Turns RD/RDA and WR/WRA commands into data-bus phase windows. A read
//   command opens rd_en T_CL clocks later for BL/2 clocks; a write command
//   opens wr_en T_CWL clocks later for BL/2 clocks (BL/2+1 with write CRC).
//   Each window carries the bankgroup/bank of its command and a beat index.
//   Protocol problems raise sticky flags cleared only by reset.
//   Ports:
//     clk    clock, all inputs sampled and all outputs updated on rising edge
//     reset  synchronous active-high reset
//     bus    ddr_data_phase_timer_if.slave (commands in, windows/flags out)
//   Build option:
//     WR_CRC_EN  when defined, each write burst carries one extra CRC clock
//                (wr_beat counts 0..BL/2); reads are unaffected.
module ddr_data_phase_timer #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int BL      = 8,
  parameter int T_CL    = 17,
  parameter int T_CWL   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  ddr_data_phase_timer_if.slave bus
);

  localparam int TAG_W = BGWIDTH + BAWIDTH;
  localparam int RB_W  = $clog2(BL/2);
  localparam int WB_W  = RB_W + 1;
  localparam logic [RB_W-1:0] RD_LAST = RB_W'(BL/2 - 1);
`ifdef WR_CRC_EN
  localparam logic [WB_W-1:0] WR_LAST = WB_W'(BL/2);
`else
  localparam logic [WB_W-1:0] WR_LAST = WB_W'(BL/2 - 1);
`endif

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} burst_state_e;

  // Command decode
  logic rd_cmd, wr_cmd, multi_cmd, rd_push, wr_push;
  logic cmd_unused;

  always_comb begin
    rd_cmd    = bus.commands[5] | bus.commands[4];
    wr_cmd    = bus.commands[1] | bus.commands[0];
    // Two or more of RD/RDA/WR/WRA at once: nothing gets enqueued.
    multi_cmd = (bus.commands[5] & bus.commands[4]) |
                (bus.commands[1] & bus.commands[0]) |
                (rd_cmd & wr_cmd);
    rd_push   = rd_cmd & ~multi_cmd;
    wr_push   = wr_cmd & ~multi_cmd;
  end

  // All other commands are irrelevant to data-bus timing.
  assign cmd_unused = ^{bus.commands[18:6], bus.commands[3:2]};

  // Latency pipelines: stage i holds a token pushed i+1 edges ago, so the
  // last stage exits exactly on the edge where the window must open.
  logic [T_CL-1:0]  rd_vld_q, rd_vld_d;
  logic [TAG_W-1:0] rd_tag_q [T_CL];
  logic [TAG_W-1:0] rd_tag_d [T_CL];
  logic [T_CWL-1:0] wr_vld_q, wr_vld_d;
  logic [TAG_W-1:0] wr_tag_q [T_CWL];
  logic [TAG_W-1:0] wr_tag_d [T_CWL];

  always_comb begin
    rd_vld_d    = {rd_vld_q[T_CL-2:0], rd_push};
    rd_tag_d[0] = {bus.bg, bus.ba};
    for (int i = 1; i < T_CL; i++) rd_tag_d[i] = rd_tag_q[i-1];
    wr_vld_d    = {wr_vld_q[T_CWL-2:0], wr_push};
    wr_tag_d[0] = {bus.bg, bus.ba};
    for (int i = 1; i < T_CWL; i++) wr_tag_d[i] = wr_tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q <= '0;
      wr_vld_q <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      wr_vld_q <= wr_vld_d;
    end
  end

  // Tag payload needs no reset: it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    rd_tag_q <= rd_tag_d;
    wr_tag_q <= wr_tag_d;
  end

  logic             rd_exit_v, wr_exit_v;
  logic [TAG_W-1:0] rd_exit_tag, wr_exit_tag;

  always_comb begin
    rd_exit_v   = rd_vld_q[T_CL-1];
    rd_exit_tag = rd_tag_q[T_CL-1];
    wr_exit_v   = wr_vld_q[T_CWL-1];
    wr_exit_tag = wr_tag_q[T_CWL-1];
  end

  // Burst FSMs and sticky flags: state register
  burst_state_e     rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic [RB_W-1:0]  rd_beat_q, rd_beat_d;
  logic [WB_W-1:0]  wr_beat_q, wr_beat_d;
  logic [TAG_W-1:0] rd_btag_q, rd_btag_d, wr_btag_q, wr_btag_d;
  logic             rd_ovl, wr_ovl;
  logic             overlap_err_q, overlap_err_d;
  logic             bus_conflict_q, bus_conflict_d;
  logic             cmd_err_q, cmd_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q     <= IDLE;
      rd_beat_q      <= '0;
      rd_btag_q      <= '0;
      wr_state_q     <= IDLE;
      wr_beat_q      <= '0;
      wr_btag_q      <= '0;
      overlap_err_q  <= 1'b0;
      bus_conflict_q <= 1'b0;
      cmd_err_q      <= 1'b0;
    end else begin
      rd_state_q     <= rd_state_d;
      rd_beat_q      <= rd_beat_d;
      rd_btag_q      <= rd_btag_d;
      wr_state_q     <= wr_state_d;
      wr_beat_q      <= wr_beat_d;
      wr_btag_q      <= wr_btag_d;
      overlap_err_q  <= overlap_err_d;
      bus_conflict_q <= bus_conflict_d;
      cmd_err_q      <= cmd_err_d;
    end
  end

  // Next-state logic. A token exiting mid-burst restarts the burst with the
  // new tags (old burst truncated); exiting on the last beat is a seamless
  // back-to-back continuation and is legal.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_beat_d  = rd_beat_q;
    rd_btag_d  = rd_btag_q;
    rd_ovl     = 1'b0;
    case (rd_state_q)
      IDLE: begin
        if (rd_exit_v) begin
          rd_state_d = BURST;
          rd_beat_d  = '0;
          rd_btag_d  = rd_exit_tag;
        end
      end
      BURST: begin
        if (rd_exit_v) begin
          rd_beat_d = '0;
          rd_btag_d = rd_exit_tag;
          rd_ovl    = (rd_beat_q != RD_LAST);
        end else if (rd_beat_q == RD_LAST) begin
          rd_state_d = IDLE;
          rd_beat_d  = '0;
        end else begin
          rd_beat_d = rd_beat_q + RB_W'(1);
        end
      end
      default: rd_state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_beat_d  = wr_beat_q;
    wr_btag_d  = wr_btag_q;
    wr_ovl     = 1'b0;
    case (wr_state_q)
      IDLE: begin
        if (wr_exit_v) begin
          wr_state_d = BURST;
          wr_beat_d  = '0;
          wr_btag_d  = wr_exit_tag;
        end
      end
      BURST: begin
        if (wr_exit_v) begin
          wr_beat_d = '0;
          wr_btag_d = wr_exit_tag;
          wr_ovl    = (wr_beat_q != WR_LAST);
        end else if (wr_beat_q == WR_LAST) begin
          wr_state_d = IDLE;
          wr_beat_d  = '0;
        end else begin
          wr_beat_d = wr_beat_q + WB_W'(1);
        end
      end
      default: wr_state_d = IDLE;
    endcase
  end

  always_comb begin
    overlap_err_d  = overlap_err_q | rd_ovl | wr_ovl;
    // Collision is judged on the enables as driven in the current cycle.
    bus_conflict_d = bus_conflict_q |
                     ((rd_state_q == BURST) & (wr_state_q == BURST));
    cmd_err_d      = cmd_err_q | multi_cmd;
  end

  // Outputs: decoded from registers only.
  always_comb begin
    bus.rd_en                = (rd_state_q == BURST);
    bus.rd_beat              = rd_beat_q;
    {bus.rd_bg, bus.rd_ba}   = rd_btag_q;
    bus.wr_en                = (wr_state_q == BURST);
    bus.wr_beat              = wr_beat_q;
    {bus.wr_bg, bus.wr_ba}   = wr_btag_q;
    bus.overlap_err          = overlap_err_q;
    bus.bus_conflict         = bus_conflict_q;
    bus.cmd_err              = cmd_err_q;
  end

endmodule

// File: tb/tb_ddr_data_phase_timer.sv
// tb_ddr_data_phase_timer
//   Directed bench for ddr_data_phase_timer (BL=8, T_CL=17, T_CWL=12).
//   Edge numbering: the edge at which the first command is sampled is edge 0;
//   outputs are examined 1 time unit after each edge.
module tb_ddr_data_phase_timer;

  localparam logic [18:0] C_NONE = 19'd0;
  localparam logic [18:0] C_ACT  = 19'd1 << 18;
  localparam logic [18:0] C_RD   = 19'd1 << 5;
  localparam logic [18:0] C_RDA  = 19'd1 << 4;
  localparam logic [18:0] C_WR   = 19'd1 << 1;
`ifdef WR_CRC_EN
  localparam int WLEN = 5;
  localparam bit CRC  = 1'b1;
`else
  localparam int WLEN = 4;
  localparam bit CRC  = 1'b0;
`endif

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  ddr_data_phase_timer_if #(.BGWIDTH(2), .BAWIDTH(2), .BL(8)) dif ();

  ddr_data_phase_timer #(
    .BGWIDTH(2), .BAWIDTH(2), .BL(8), .T_CL(17), .T_CWL(12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_with(input logic [18:0] c, input logic [1:0] g,
                           input logic [1:0] a, input logic r);
    dif.commands = c;
    dif.bg       = g;
    dif.ba       = a;
    reset        = r;
    @(posedge clk);
    #1;
    dif.commands = C_NONE;
    dif.bg       = 2'd0;
    dif.ba       = 2'd0;
    reset        = 1'b0;
  endtask

  task automatic do_reset();
    edge_with(C_NONE, 2'd0, 2'd0, 1'b1);
    edge_with(C_NONE, 2'd0, 2'd0, 1'b1);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    reset        = 1'b1;
    dif.commands = C_NONE;
    dif.bg       = 2'd0;
    dif.ba       = 2'd0;

    // Reset state
    do_reset();
    chk("rst_rd_en", dif.rd_en, 0);
    chk("rst_wr_en", dif.wr_en, 0);
    chk("rst_rd_beat", dif.rd_beat, 0);
    chk("rst_wr_beat", dif.wr_beat, 0);
    chk("rst_tags", {dif.rd_bg, dif.rd_ba, dif.wr_bg, dif.wr_ba}, 0);
    chk("rst_flags", {dif.overlap_err, dif.bus_conflict, dif.cmd_err}, 0);

    // Single read: RD bg=0 ba=1 at edge 0 -> window after edges 17..20
    for (int t = 0; t <= 24; t++) begin
      if (t == 0) edge_with(C_RD, 2'd0, 2'd1, 1'b0);
      else        edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("rd1_en", dif.rd_en, (t >= 17 && t <= 20));
      chk("rd1_wr_en", dif.wr_en, 0);
      if (t >= 17 && t <= 20) begin
        chk("rd1_ba", dif.rd_ba, 1);
        chk("rd1_bg", dif.rd_bg, 0);
        chk("rd1_beat", dif.rd_beat, t - 17);
      end
    end
    chk("rd1_flags", {dif.overlap_err, dif.bus_conflict, dif.cmd_err}, 0);

    // Single write: WR bg=1 ba=2 at edge 0 -> window after edges 12..(11+WLEN)
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      if (t == 0) edge_with(C_WR, 2'd1, 2'd2, 1'b0);
      else        edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("wr1_en", dif.wr_en, (t >= 12 && t <= 11 + WLEN));
      chk("wr1_rd_en", dif.rd_en, 0);
      if (t >= 12 && t <= 11 + WLEN) begin
        chk("wr1_ba", dif.wr_ba, 2);
        chk("wr1_bg", dif.wr_bg, 1);
        chk("wr1_beat", dif.wr_beat, t - 12);
      end
    end
    chk("wr1_flags", {dif.overlap_err, dif.bus_conflict, dif.cmd_err}, 0);

    // Seamless reads: RD ba=1 at 0, RD ba=3 at 4 -> continuous 17..24
    do_reset();
    for (int t = 0; t <= 27; t++) begin
      if (t == 0)      edge_with(C_RD, 2'd0, 2'd1, 1'b0);
      else if (t == 4) edge_with(C_RD, 2'd0, 2'd3, 1'b0);
      else             edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("seam_en", dif.rd_en, (t >= 17 && t <= 24));
      if (t >= 17 && t <= 20) begin
        chk("seam_ba_a", dif.rd_ba, 1);
        chk("seam_beat_a", dif.rd_beat, t - 17);
      end
      if (t >= 21 && t <= 24) begin
        chk("seam_ba_b", dif.rd_ba, 3);
        chk("seam_beat_b", dif.rd_beat, t - 21);
      end
      chk("seam_ovl", dif.overlap_err, 0);
    end

    // Overlap: RDA at 0 and 2 -> restart at 19, window 17..22
    do_reset();
    for (int t = 0; t <= 25; t++) begin
      if (t == 0)      edge_with(C_RDA, 2'd1, 2'd0, 1'b0);
      else if (t == 2) edge_with(C_RDA, 2'd2, 2'd1, 1'b0);
      else             edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("ovl_en", dif.rd_en, (t >= 17 && t <= 22));
      chk("ovl_flag", dif.overlap_err, (t >= 19));
      if (t >= 17 && t <= 18) chk("ovl_beat_a", dif.rd_beat, t - 17);
      if (t >= 19 && t <= 22) begin
        chk("ovl_beat_b", dif.rd_beat, t - 19);
        chk("ovl_tag_b", {dif.rd_bg, dif.rd_ba}, 4'b1001);
      end
    end

    // Collision: RD at 0, WR at 5 -> both windows from 17, bus_conflict from 18
    do_reset();
    for (int t = 0; t <= 24; t++) begin
      if (t == 0)      edge_with(C_RD, 2'd0, 2'd0, 1'b0);
      else if (t == 5) edge_with(C_WR, 2'd0, 2'd0, 1'b0);
      else             edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("col_rd_en", dif.rd_en, (t >= 17 && t <= 20));
      chk("col_wr_en", dif.wr_en, (t >= 17 && t <= 16 + WLEN));
      chk("col_flag", dif.bus_conflict, (t >= 18));
    end

    // Write pair at 0 and 4: seamless without CRC, overlap with CRC
    do_reset();
    for (int t = 0; t <= 24; t++) begin
      if (t == 0)      edge_with(C_WR, 2'd0, 2'd1, 1'b0);
      else if (t == 4) edge_with(C_WR, 2'd0, 2'd2, 1'b0);
      else             edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("wp_en", dif.wr_en, (t >= 12 && t <= 15 + WLEN));
      chk("wp_ovl", dif.overlap_err, (CRC && t >= 16));
      if (t >= 12 && t <= 15) begin
        chk("wp_ba_a", dif.wr_ba, 1);
        chk("wp_beat_a", dif.wr_beat, t - 12);
      end
      if (t >= 16 && t <= 15 + WLEN) begin
        chk("wp_ba_b", dif.wr_ba, 2);
        chk("wp_beat_b", dif.wr_beat, t - 16);
      end
    end

    // Illegal multi-command: RD+WR at 0 -> cmd_err, no window
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      if (t == 0) edge_with(C_RD | C_WR, 2'd0, 2'd1, 1'b0);
      else        edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("cmd_err", dif.cmd_err, 1);
      chk("cmd_rd_en", dif.rd_en, 0);
      chk("cmd_wr_en", dif.wr_en, 0);
    end

    // Ignored command: ACT has no effect
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      if (t == 0) edge_with(C_ACT, 2'd0, 2'd1, 1'b0);
      else        edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("act_en", {dif.rd_en, dif.wr_en}, 0);
      chk("act_flags", {dif.overlap_err, dif.bus_conflict, dif.cmd_err}, 0);
    end

    // Reset mid-flight: RD at 0, reset at edge 10 -> no window
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      if (t == 0)       edge_with(C_RD, 2'd0, 2'd1, 1'b0);
      else if (t == 10) edge_with(C_NONE, 2'd0, 2'd0, 1'b1);
      else              edge_with(C_NONE, 2'd0, 2'd0, 1'b0);
      chk("mid_rd_en", dif.rd_en, 0);
      chk("mid_flags", {dif.overlap_err, dif.bus_conflict, dif.cmd_err}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
